// File: rtl/if_pkg.sv
// Shared fetch-stage definitions: bubble encoding, reset fetch address and
// the fetch control states. Decode imports NOP_INSTR from here as well.
package if_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    DISCARD = 2'd2
  } if_state_t;

  // Sequential fetch address; wraps silently at 2^32.
  function automatic logic [31:0] next_fetch_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding slot for a fetched {instr, pc} pair that arrived while
// decode was stalled. Flush wins over push, push wins over pop.
module fetch_skid_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] push_instr,
  input  logic [31:0] push_pc,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc
);

  logic        valid_reg;
  logic [31:0] instr_reg;
  logic [31:0] pc_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      instr_reg <= '0;
      pc_reg    <= '0;
    end else if (flush) begin
      valid_reg <= 1'b0;
    end else if (push) begin
      valid_reg <= 1'b1;
      instr_reg <= push_instr;
      pc_reg    <= push_pc;
    end else if (pop) begin
      valid_reg <= 1'b0;
    end
  end

  assign valid = valid_reg;
  assign instr = instr_reg;
  assign pc    = pc_reg;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, runs the single-outstanding
// imem handshake, parks stalled responses and drives the IF/ID register.
module if_stage #(
  parameter logic [31:0] RESET_PC  = if_pkg::DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = if_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        IFWrite,
  input  logic        Branch,
  input  logic        Jump,
  input  logic [31:0] JumpAddr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction_id,
  output logic [31:0] PC_id,
  output logic        valid_id
);

  import if_pkg::*;

  if_state_t   state_reg, state_next;
  logic [31:0] pc_f_reg, pc_f_next;
  logic [31:0] req_pc_reg, req_pc_next;
  logic [31:0] id_instr_reg, id_instr_next;
  logic [31:0] id_pc_reg, id_pc_next;
  logic        id_valid_reg, id_valid_next;

  logic        redirect;
  logic        rsp_busy;
  logic        buf_empty_at_end;
  logic        issue;
  logic        accept;

  logic        buf_flush;
  logic        buf_push;
  logic        buf_pop;
  logic        buf_valid;
  logic [31:0] buf_instr;
  logic [31:0] buf_pc;

  // Branch/Jump are only trusted when decode is actually advancing.
  assign redirect = (Branch | Jump) & IFWrite;
  assign rsp_busy = imem_rvalid & (state_reg == BUSY);

  // A new request may only go out if the skid slot is guaranteed free at the
  // end of this cycle, so one in flight plus one parked is the worst case.
  assign buf_empty_at_end = IFWrite | (~buf_valid & ~rsp_busy);
  assign issue  = rst_n & ~redirect
                & ((state_reg == IDLE) | imem_rvalid)
                & buf_empty_at_end;
  assign accept = issue & imem_ready;

  assign imem_req  = issue;
  assign imem_addr = pc_f_reg;

  assign buf_flush = redirect;
  assign buf_push  = rsp_busy & ~IFWrite;
  assign buf_pop   = IFWrite & buf_valid & ~redirect;

  fetch_skid_buf u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (buf_flush),
    .push       (buf_push),
    .pop        (buf_pop),
    .push_instr (imem_rdata),
    .push_pc    (req_pc_reg),
    .valid      (buf_valid),
    .instr      (buf_instr),
    .pc         (buf_pc)
  );

  always_comb begin
    state_next = state_reg;
    if (accept) begin
      state_next = BUSY;
    end else if (redirect && (state_reg == BUSY) && !imem_rvalid) begin
      state_next = DISCARD;
    end else if (imem_rvalid) begin
      state_next = IDLE;
    end
  end

  always_comb begin
    pc_f_next   = pc_f_reg;
    req_pc_next = req_pc_reg;
    if (redirect) begin
      pc_f_next = JumpAddr;
    end else if (accept) begin
      pc_f_next   = next_fetch_pc(pc_f_reg);
      req_pc_next = pc_f_reg;
    end
  end

  // IF/ID only moves when decode takes it; redirect outranks everything,
  // including a BUSY response landing in the same cycle.
  always_comb begin
    id_instr_next = id_instr_reg;
    id_pc_next    = id_pc_reg;
    id_valid_next = id_valid_reg;
    if (IFWrite) begin
      if (redirect) begin
        id_instr_next = NOP_INSTR;
        id_pc_next    = '0;
        id_valid_next = 1'b0;
      end else if (buf_valid) begin
        id_instr_next = buf_instr;
        id_pc_next    = buf_pc;
        id_valid_next = 1'b1;
      end else if (rsp_busy) begin
        id_instr_next = imem_rdata;
        id_pc_next    = req_pc_reg;
        id_valid_next = 1'b1;
      end else begin
        id_instr_next = NOP_INSTR;
        id_pc_next    = '0;
        id_valid_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      pc_f_reg     <= RESET_PC;
      req_pc_reg   <= '0;
      id_instr_reg <= NOP_INSTR;
      id_pc_reg    <= '0;
      id_valid_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_f_reg     <= pc_f_next;
      req_pc_reg   <= req_pc_next;
      id_instr_reg <= id_instr_next;
      id_pc_reg    <= id_pc_next;
      id_valid_reg <= id_valid_next;
    end
  end

  assign Instruction_id = id_instr_reg;
  assign PC_id          = id_pc_reg;
  assign valid_id       = id_valid_reg;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: latency-configurable memory model, a program-order
// PC stream model checked every cycle, and directed cycle-exact checks.
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n, IFWrite, Branch, Jump, imem_ready, imem_rvalid;
  logic [31:0] JumpAddr, imem_rdata;
  logic        imem_req, valid_id;
  logic [31:0] imem_addr, Instruction_id, PC_id;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .IFWrite        (IFWrite),
    .Branch         (Branch),
    .Jump           (Jump),
    .JumpAddr       (JumpAddr),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .Instruction_id (Instruction_id),
    .PC_id          (PC_id),
    .valid_id       (valid_id)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;

  rsp_t        mq[$];
  int          lat = 1;
  int          cyc = 0;
  int          nvec = 0;
  int          nfail = 0;
  int          ndeliv = 0;
  logic        outstanding = 1'b0;
  logic [31:0] exp_pc, exp_fetch, m_pc, m_instr;
  logic        m_valid;
  logic        last_req, last_acc;
  logic [31:0] last_addr;
  logic [15:0] rdy_pat = 16'b1101_1011_0111_1101;
  logic [15:0] ifw_pat = 16'b1111_0111_1101_1111;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bubble();
    m_valid = 1'b0;
    m_pc    = 32'h0;
    m_instr = NOP;
  endtask

  // One clock: drive at negedge, check handshake outputs, then check IF/ID
  // against the program-order model just after the rising edge.
  task automatic step(input logic rst, input logic ifw, input logic br, input logic jp,
                      input logic [31:0] ja, input logic rdy);
    logic redir;
    @(negedge clk);
    rst_n = rst; IFWrite = ifw; Branch = br; Jump = jp; JumpAddr = ja; imem_ready = rdy;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end
    #1;
    redir     = rst & ifw & (br | jp);
    last_req  = imem_req;
    last_addr = imem_addr;
    last_acc  = imem_req & imem_ready;
    if (!rst) chk("req_in_reset", 32'(imem_req), 32'h0);
    if (redir) chk("req_on_redirect", 32'(imem_req), 32'h0);
    chk("req_while_busy", 32'(imem_req & outstanding & ~imem_rvalid), 32'h0);
    if (last_acc) chk("fetch_addr", imem_addr, exp_fetch);
    @(posedge clk);
    #1;
    if (imem_rvalid) outstanding = 1'b0;
    if (last_acc) begin
      mq.push_back('{addr: last_addr, due: cyc + lat});
      outstanding = 1'b1;
      exp_fetch   = exp_fetch + 32'd4;
    end
    if (!rst) begin
      outstanding = 1'b0;
      exp_fetch   = RST_PC;
      exp_pc      = RST_PC;
      bubble();
    end else if (redir) begin
      exp_fetch = ja;
      exp_pc    = ja;
      bubble();
      $display("[%0d] redirect to %h", cyc, ja);
    end else if (ifw) begin
      if (valid_id) begin
        m_valid = 1'b1;
        m_pc    = exp_pc;
        m_instr = mem_word(exp_pc);
        exp_pc  = exp_pc + 32'd4;
        ndeliv++;
        $display("[%0d] id pc=%h instr=%h", cyc, PC_id, Instruction_id);
      end else begin
        bubble();
      end
    end
    chk("valid_id", 32'(valid_id), 32'(m_valid));
    chk("PC_id", PC_id, m_pc);
    chk("Instruction_id", Instruction_id, m_instr);
    cyc++;
  endtask

  task automatic wait_accept();
    int k;
    k = 0;
    do begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      k++;
    end while (!last_acc && k < 8);
    chk("wait_accept", 32'(last_acc), 32'h1);
  endtask

  initial begin
    int d0;
    rst_n = 1'b0; IFWrite = 1'b1; Branch = 1'b0; Jump = 1'b0; JumpAddr = 32'h0;
    imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    exp_pc = RST_PC; exp_fetch = RST_PC;
    bubble();

    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("rst_valid", 32'(valid_id), 32'h0);
    chk("rst_pc", PC_id, 32'h0);
    chk("rst_instr", Instruction_id, 32'h0000_0013);

    // Zero-wait startup: fetches 0,4,8; IF/ID valid from cycle 2.
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("c0_req", 32'(last_req), 32'h1);
    chk("c0_addr", last_addr, 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("c1_addr", last_addr, 32'h4);
    chk("c2_valid", 32'(valid_id), 32'h1);
    chk("c2_pc", PC_id, 32'h0);
    chk("c2_instr", Instruction_id, 32'hC0DE_0000);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("c2_addr", last_addr, 32'h8);
    chk("c3_pc", PC_id, 32'h4);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("c4_pc", PC_id, 32'h8);

    // Three stall cycles at PC 8, with an ignored Branch in the middle.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, (i == 1), 1'b0, 32'h300, 1'b1);
      chk("stall_req", 32'(last_req), 32'h0);
      chk("stall_pc", PC_id, 32'h8);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("unstall_addr", last_addr, 32'h10);
    chk("unstall_pc0", PC_id, 32'hC);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("unstall_pc1", PC_id, 32'h10);
    repeat (2) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    // Jump with a response landing the same cycle.
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 1'b1);
    chk("jmp_t_valid", 32'(valid_id), 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("jmp_t1_req", 32'(last_req), 32'h1);
    chk("jmp_t1_addr", last_addr, 32'h100);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("jmp_t3_valid", 32'(valid_id), 32'h1);
    chk("jmp_t3_pc", PC_id, 32'h100);
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    // Two-cycle memory, toggling ready, sporadic stalls with ignored branches.
    lat = 2;
    d0  = ndeliv;
    for (int i = 0; i < 32; i++) begin
      step(1'b1, ifw_pat[i % 16], ~ifw_pat[i % 16], 1'b0, 32'h300, rdy_pat[i % 16]);
    end
    chk("slow_progress", 32'((ndeliv - d0) >= 4), 32'h1);

    // Redirect while BUSY without a response: stale word must be discarded.
    wait_accept();
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'h200, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("disc_req", 32'(last_req), 32'h1);
    chk("disc_addr", last_addr, 32'h200);
    repeat (2) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("disc_pc", PC_id, 32'h200);
    chk("disc_valid", 32'(valid_id), 32'h1);

    // Reset with a request in flight; its response arrives after release.
    lat = 3;
    wait_accept();
    repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("rstmid_req", 32'(last_req), 32'h1);
    chk("rstmid_addr", last_addr, 32'h0);
    chk("rstmid_valid", 32'(valid_id), 32'h0);
    chk("rstmid_pc", PC_id, 32'h0);
    chk("rstmid_instr", Instruction_id, 32'h0000_0013);
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("rstmid_first_pc", PC_id, 32'h0);
    chk("rstmid_first_valid", 32'(valid_id), 32'h1);
    chk("rstmid_first_instr", Instruction_id, 32'hC0DE_0000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage RV32I pipeline, directly upstream of the decode stage. Owns the fetch PC, issues requests to the instruction memory over a request/ready/valid handshake, and holds at most one returned word in a skid buffer. Drives the IF/ID pipeline register (`Instruction_id`, `PC_id`) and consumes decode's `IFWrite`, `Branch`, `Jump` and `JumpAddr` for stalls and redirects.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `NOP_INSTR`, default 32'h0000_0013 (`addi x0,x0,0`): bubble value loaded into `Instruction_id`.

Ports:
- `clk`  in  1  rising-edge clock; the only clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `IFWrite`  in  1  decode accepts a new IF/ID value this cycle; 0 means stall.
- `Branch`  in  1  taken conditional branch resolved in decode.
- `Jump`  in  1  JAL/JALR in decode.
- `JumpAddr`  in  32  redirect target.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  32  fetch address, word aligned.
- `imem_ready`  in  1  memory accepts the request this cycle.
- `imem_rvalid`  in  1  response data valid.
- `imem_rdata`  in  32  instruction word.
- `Instruction_id`  out  32  IF/ID instruction.
- `PC_id`  out  32  IF/ID PC.
- `valid_id`  out  1  IF/ID holds a real instruction; 0 means bubble.

## Operation
- Redirect is `(Branch | Jump) & IFWrite`. While `IFWrite`=0, `Branch` and `Jump` are ignored, because decode operands are stale during a load-use stall.
- Control FSM:
  - IDLE: no request outstanding.
  - BUSY: one request outstanding; its PC is held in `req_pc`.
  - DISCARD: one request outstanding and its response will be dropped.
- FSM transitions:
  - Accepted request (`imem_req & imem_ready`) moves to BUSY, from any state.
  - A redirect while BUSY, with no `imem_rvalid` in the same cycle, moves to DISCARD.
  - `imem_rvalid` with no new issue returns to IDLE.
- Response handling:
  - In BUSY, a response goes to IF/ID if `IFWrite`=1; otherwise it goes to the skid buffer (`buf_valid`, `buf_instr`, `buf_pc`).
  - In DISCARD, a response is dropped.
  - `imem_rvalid` in IDLE is a protocol violation and is ignored.
- IF/ID update happens only when `IFWrite`=1. Priority:
  1. Redirect: load `NOP_INSTR`, `PC_id`=0, `valid_id`=0, clear the skid buffer, `pc_f`<=`JumpAddr`. The redirect also drops a BUSY response arriving in this cycle.
  2. Buffer valid: load the buffer contents, `valid_id`=1.
  3. BUSY response this cycle: load `imem_rdata` and `req_pc`, `valid_id`=1.
  4. Otherwise: load a bubble.
- When `IFWrite`=0, IF/ID holds all three outputs unchanged.
- Issue condition, `imem_req`=1 when all of the following hold:
  - no redirect this cycle;
  - the state is IDLE, or `imem_rvalid` arrives this cycle;
  - the skid buffer will be empty at the end of the cycle, i.e. `IFWrite`=1, or nothing is buffered and nothing is arriving.
- `imem_addr`=`pc_f`. On acceptance, `pc_f`<=`pc_f`+4 (mod 2^32, wrap with no flag) and `req_pc`<=`pc_f`.
- Because of the issue condition, there is never more than one outstanding request plus one buffered word, so the buffer cannot overflow.

## Timing
- Reset (`rst_n`=0 at a rising edge):
  - `pc_f`=`RESET_PC`; state IDLE; buffer empty.
  - `Instruction_id`=`NOP_INSTR`, `PC_id`=0, `valid_id`=0.
  - `imem_req`=0 while `rst_n`=0.
- Reset mid-request: any outstanding response is forgotten, and a later `imem_rvalid` arriving in IDLE is ignored.
- Startup with zero-wait memory (`imem_ready`=1, `imem_rvalid` one cycle after acceptance):
  - cycle 0 after release: request `RESET_PC`;
  - cycle 1: response arrives;
  - cycle 2: `Instruction_id` valid.
- Steady state: one instruction per cycle.
- Redirect at cycle t:
  - t+1: `valid_id`=0, `imem_req` with `imem_addr`=`JumpAddr`; issue is permitted in the same cycle the discarded response arrives;
  - t+3: target instruction in IF/ID.
- A stall under zero-wait memory parks exactly one word in the buffer and holds `imem_req` low.

## Structure
- Shared package `if_pkg` holds `NOP_INSTR`, the `if_state_t` enum (IDLE/BUSY/DISCARD) and the default `RESET_PC`; decode reuses `NOP_INSTR` from it.
- One sub-module: `fetch_skid_buf`, a 1-entry buffer of {instr, pc} with push, pop and flush.
- The rest is the top level: FSM, PC register and IF/ID register.

## Test plan
- Reset release, zero-wait memory: `imem_addr` sequence 0, 4, 8; `PC_id`=0 at cycle 2, 4 at cycle 3; `valid_id`=1 from cycle 2.
- `IFWrite`=0 for 3 cycles at `PC_id`=8:
  - IF/ID holds 8;
  - the word at 0xC is buffered and `imem_req`=0;
  - after release, `PC_id` runs 0xC, 0x10 with no gap or duplicate.
- `Jump`=1, `JumpAddr`=0x100 with a request outstanding: the next IF/ID is a bubble, the stale response is dropped, and `PC_id`=0x100 appears 3 cycles after the redirect.
- `Branch`=1 with `IFWrite`=0: ignored, and `pc_f` is unchanged.
- Memory with 2-cycle `imem_rvalid` latency and `imem_ready` toggling: no lost or duplicated PCs, bubbles inserted with `valid_id`=0, and `imem_req` never asserted while BUSY without `imem_rvalid`.
- `rst_n` low while BUSY, followed by a late `imem_rvalid`: outputs hold their reset values and the first post-reset fetch is to `RESET_PC`.
